uart_tx: RTL and testbench

UART transmitter for 8 data bits, 1 start bit, 1 stop bit, LSB first, 115200 baud from a 25 MHz clock by default. It is the transmit counterpart of the team's 16x-oversampling UART receiver and uses the same baud-tick arithmetic, so both ends agree on the bit period. A parallel byte enters through a start/busy handshake. The block drives the serial line and pulses a done flag when the stop bit completes.

---
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial output of uart_tx, bundled for port connection.
// master drives the byte request; slave is the transmitter.
interface uart_tx_if;
   logic       i_TX_START;
   logic [7:0] i_TX_DATA;
   logic       o_TX_SERIAL;
   logic       o_TX_BUSY;
   logic       o_TX_DONE;

   modport master (
      output i_TX_START,
      output i_TX_DATA,
      input  o_TX_SERIAL,
      input  o_TX_BUSY,
      input  o_TX_DONE
   );

   modport slave (
      input  i_TX_START,
      input  i_TX_DATA,
      output o_TX_SERIAL,
      output o_TX_BUSY,
      output o_TX_DONE
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, 1 start, 1 stop, LSB first; each bit is 16 baud ticks.
// Define UART_TX_PARITY_EN to send an even-parity bit between data bit 7 and the stop bit.
module uart_tx #(
   parameter int BAUD_RATE = 115200,
   parameter int CLK_FREQ  = 25000000
) (
   input  logic     i_CLK,
   input  logic     i_RESET,
   uart_tx_if.slave tx
);
   localparam int MAX_COUNT = CLK_FREQ / (BAUD_RATE * 16) - 1;
   localparam int CNT_W     = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [3:0]       tick_q, tick_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             serial_q, serial_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic tick;
   logic bit_end;

   assign tick    = (baud_q == MAX_CNT);
   assign bit_end = tick && (tick_q == 4'hF);

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = tick ? '0 : baud_q + CNT_W'(1);
      tick_d  = tick_q + {3'b000, tick};
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Counters sit at zero so the first bit period starts on the accepting edge.
            baud_d = '0;
            tick_d = '0;
            bit_d  = '0;
            if (tx.i_TX_START) begin
               state_d = S_START;
               shift_d = tx.i_TX_DATA;
`ifdef UART_TX_PARITY_EN
               parity_d = ^tx.i_TX_DATA;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            tick_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the line and busy change on the edge itself.
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_STOP) && bit_end;
      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: serial_d = parity_d;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

   assign tx.o_TX_SERIAL = serial_q;
   assign tx.o_TX_BUSY   = busy_q;
   assign tx.o_TX_DONE   = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-position model plus mid-bit receiver, randomized and directed frames.
// Honours UART_TX_PARITY_EN for the 11-bit frame variant.
module tb_uart_tx;
   localparam int BAUD_RATE = 115200;
   localparam int CLK_FREQ  = 25000000;
   localparam int BIT_CLKS  = 16 * (CLK_FREQ / (BAUD_RATE * 16));
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam int FRAME_LIT  = 2288;
`else
   localparam int FRAME_BITS = 10;
   localparam int FRAME_LIT  = 2080;
`endif
   localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

   logic clk = 1'b0;
   logic rst = 1'b0;
   uart_tx_if bus();

   uart_tx #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ)) dut (
      .i_CLK   (clk),
      .i_RESET (rst),
      .tx      (bus)
   );

   always #20 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: after an accept, the line is simply bit[pos / BIT_CLKS] of the frame.
   logic exp_serial = 1'b1;
   logic exp_busy   = 1'b0;
   logic exp_done   = 1'b0;
   bit   m_busy     = 1'b0;
   int   m_pos      = 0;
   logic m_bits [FRAME_BITS];
   logic [7:0] exp_q [$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy     = 1'b0;
         exp_serial = 1'b1;
         exp_busy   = 1'b0;
         exp_done   = 1'b0;
         exp_q.delete();
      end else if (!m_busy) begin
         exp_done = 1'b0;
         if (bus.i_TX_START) begin
            for (int i = 0; i < FRAME_BITS; i++) m_bits[i] = 1'b1;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = bus.i_TX_DATA[i];
`ifdef UART_TX_PARITY_EN
            m_bits[9] = ^bus.i_TX_DATA;
`endif
            exp_q.push_back(bus.i_TX_DATA);
            m_busy     = 1'b1;
            m_pos      = 0;
            exp_serial = 1'b0;
            exp_busy   = 1'b1;
         end else begin
            exp_serial = 1'b1;
            exp_busy   = 1'b0;
         end
      end else begin
         m_pos++;
         if (m_pos == FRAME_CLKS) begin
            m_busy     = 1'b0;
            exp_serial = 1'b1;
            exp_busy   = 1'b0;
            exp_done   = 1'b1;
         end else begin
            exp_serial = m_bits[m_pos / BIT_CLKS];
         end
      end
   end

   // Per-cycle compare plus a mid-bit sampling receiver.
   int         done_count = 0;
   int         rx_count   = 0;
   bit         rx_active  = 1'b0;
   int         rx_cnt     = 0;
   int         rx_idx;
   logic [7:0] rx_byte    = '0;
   logic [7:0] last_rx    = '0;
   logic       last_par   = 1'b0;
   logic [7:0] rx_exp;

   always @(negedge clk) begin
      check("serial", 32'(bus.o_TX_SERIAL), 32'(exp_serial));
      check("busy",   32'(bus.o_TX_BUSY),   32'(exp_busy));
      check("done",   32'(bus.o_TX_DONE),   32'(exp_done));
      if (bus.o_TX_DONE) done_count++;
      if (rst) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (!bus.o_TX_SERIAL) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % BIT_CLKS == BIT_CLKS / 2) begin
            rx_idx = rx_cnt / BIT_CLKS;
            if (rx_idx == 0) begin
               check("rx_start_bit", 32'(bus.o_TX_SERIAL), 32'd0);
            end else if (rx_idx <= 8) begin
               rx_byte[rx_idx-1] = bus.o_TX_SERIAL;
            end else if (rx_idx == FRAME_BITS - 1) begin
               check("rx_stop_bit", 32'(bus.o_TX_SERIAL), 32'd1);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rx_unexpected_frame: got %02h, expected no frame", rx_byte);
               end else begin
                  rx_exp = exp_q.pop_front();
                  if (rx_byte !== rx_exp) begin
                     errors++;
                     $display("FAIL rx_byte: got %02h, expected %02h", rx_byte, rx_exp);
                  end
               end
               last_rx = rx_byte;
               rx_count++;
               rx_active = 1'b0;
               $display("frame received: %02h at %0t", rx_byte, $time);
            end else begin
               last_par = bus.o_TX_SERIAL;
               check("rx_parity", 32'(bus.o_TX_SERIAL), 32'(^rx_byte));
            end
         end
      end
   end

   // Raise start in the current cycle and drop it just after the accepting edge.
   task automatic start_now(input logic [7:0] d);
      bus.i_TX_DATA  = d;
      bus.i_TX_START = 1'b1;
      @(posedge clk);
      #1;
      bus.i_TX_START = 1'b0;
      bus.i_TX_DATA  = 8'($urandom);
   endtask

   task automatic start_frame(input logic [7:0] d);
      @(negedge clk);
      #1;
      start_now(d);
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         n++;
         if (bus.o_TX_DONE) break;
         if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d clocks, expected one", n);
            break;
         end
      end
   endtask

   int n1, n2, dc0, rc0;

   initial begin
      bus.i_TX_START = 1'b0;
      bus.i_TX_DATA  = 8'h00;
      #5 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_serial", 32'(bus.o_TX_SERIAL), 32'd1);
      check("reset_busy",   32'(bus.o_TX_BUSY),   32'd0);
      check("reset_done",   32'(bus.o_TX_DONE),   32'd0);
      rst = 1'b0;
      repeat (500) @(posedge clk);

      // 0x55: latency from accepting edge to done
      dc0 = done_count;
      start_frame(8'h55);
      wait_done(FRAME_CLKS + 50, n1);
      check("latency_55", 32'(n1), 32'(FRAME_LIT));
      repeat (5) @(posedge clk);
      check("rx_55", 32'(last_rx), 32'h55);
      check("done_once_55", 32'(done_count - dc0), 32'd1);

      // back-to-back: second start raised in the done cycle
      start_frame(8'hA5);
      wait_done(FRAME_CLKS + 50, n1);
      start_now(8'h3C);
`ifdef UART_TX_PARITY_EN
      check("parity_A5", 32'(last_par), 32'd0);
`endif
      wait_done(FRAME_CLKS + 50, n2);
      check("b2b_first",  32'(n1), 32'(FRAME_LIT));
      check("b2b_second", 32'(n2), 32'(FRAME_LIT));
      repeat (5) @(posedge clk);
      check("rx_3C", 32'(last_rx), 32'h3C);

      // start during a frame is ignored
      dc0 = done_count;
      rc0 = rx_count;
      start_frame(8'h00);
      repeat (999) @(posedge clk);
      #1;
      start_now(8'hFF);
      wait_done(FRAME_CLKS + 50, n1);
      repeat (300) @(posedge clk);
      check("ignore_done_count", 32'(done_count - dc0), 32'd1);
      check("ignore_rx_count",   32'(rx_count - rc0),   32'd1);
      check("rx_00", 32'(last_rx), 32'h00);

      // reset mid-frame
      dc0 = done_count;
      start_frame(8'h0F);
      repeat (699) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midreset_serial", 32'(bus.o_TX_SERIAL), 32'd1);
      check("midreset_busy",   32'(bus.o_TX_BUSY),   32'd0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (300) @(posedge clk);
      check("midreset_no_done", 32'(done_count - dc0), 32'd0);
      start_frame(8'h81);
      wait_done(FRAME_CLKS + 50, n1);
      repeat (5) @(posedge clk);
      check("rx_81", 32'(last_rx), 32'h81);

`ifdef UART_TX_PARITY_EN
      start_frame(8'h01);
      wait_done(FRAME_CLKS + 50, n1);
      check("parity_01", 32'(last_par), 32'd1);
`endif

      // random frames, random gaps, spurious starts mid-frame
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         start_frame(8'($urandom));
         repeat ($urandom_range(100, 1800)) @(posedge clk);
         #1;
         start_now(8'($urandom));
         wait_done(FRAME_CLKS + 50, n1);
      end
      repeat (300) @(posedge clk);
      check("all_frames_received", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
